match_controller: RTL and testbench
===================================

// Module: match_controller
// PURPOSE
//  Parametrised match sequencer for the duel game: best-of-N rounds, configurable HP,
//  post-hit invulnerability window, edge-detected select and inter-round pause.
//  Sits above Player/Enemy/bullet blocks: consumes their hit/shield flags, drives
//  game state, HP, round scores, a round_reset pulse (respawn sprites) and ai_tick.
// PARAMETERS
//  HP_MAX             3    HP per side at start of each round (>=1)
//  ROUNDS_TO_WIN      2    rounds a side must take to win the match (>=1)
//  INVULN_CYCLES      32   cycles a side ignores hits after an accepted hit (0 = none)
//  ROUND_PAUSE_CYCLES 64   cycles spent in S_ROUND_END before next round (>=1)
//  AI_PERIOD_LOG2     7    ai_tick period = 2**AI_PERIOD_LOG2 cycles of S_PLAY
//  derived: HW=$clog2(HP_MAX+1), RW=$clog2(ROUNDS_TO_WIN+1)
// PORTS
//  clk            in   1   system clock, all logic rising-edge
//  rst            in   1   asynchronous reset, active-high
//  select         in   1   level button; only its rising edge is used
//  player_hit     in   1   bullet contact on player this cycle
//  player_shield  in   1   player shield up (blocks hit)
//  enemy_hit      in   1   bullet contact on enemy this cycle
//  enemy_shield   in   1   enemy shield up (blocks hit)
//  o_state        out  3   0 IDLE,1 PLAY,2 ROUND_END,3 WIN,4 LOSE
//  o_is_gaming    out  1   o_state==PLAY
//  o_player_hp    out  HW  player HP
//  o_enemy_hp     out  HW  enemy HP
//  o_player_rounds out RW  rounds won by player
//  o_enemy_rounds out  RW  rounds won by enemy
//  o_player_invuln out 1   player invulnerability counter nonzero
//  o_enemy_invuln out  1   enemy invulnerability counter nonzero
//  o_round_reset  out  1   one-cycle pulse at each round start
//  o_ai_tick      out  1   one-cycle strobe for enemy random-move update
// BEHAVIOUR
//  Reset: state IDLE; HP=HP_MAX both; rounds=0; invuln cnts=0; sel_q=0; ai cnt=0;
//   o_round_reset=0, o_ai_tick=0. Reset mid-match aborts immediately, no residue.
//  sel_rise = select & ~sel_q (sel_q registered); held select yields one event.
//  IDLE: sel_rise -> PLAY next cycle; HP reload, rounds clear, o_round_reset=1 that cycle.
//  PLAY, per side: hit accepted iff hit & ~shield & invuln==0 & hp!=0.
//   Accepted: hp<=hp-1, invuln<=INVULN_CYCLES. Else invuln decrements to 0, holds 0.
//   Hits while invulnerable/shielded are dropped, not queued. Both sides may be hit same cycle.
//  Round end checked on registered HP (1 cycle after the lethal hit):
//   both 0 -> draw, no score, -> ROUND_END.
//   enemy 0 only -> player_rounds+1; if new value==ROUNDS_TO_WIN -> WIN else ROUND_END.
//   player 0 only -> enemy_rounds+1; if new value==ROUNDS_TO_WIN -> LOSE else ROUND_END.
//  ROUND_END: pause cnt loads ROUND_PAUSE_CYCLES-1 on entry, counts to 0, then -> PLAY with
//   HP reload, invuln cleared, o_round_reset=1 on the entry cycle. Hits ignored.
//  WIN/LOSE: HP and rounds frozen; sel_rise -> IDLE. select ignored in PLAY/ROUND_END.
//  ai cnt (AI_PERIOD_LOG2 bits) increments only in PLAY, wraps, cleared in other states;
//   o_ai_tick=1 (registered) on cycle after cnt==all ones. Never asserted outside PLAY.
//  No arithmetic underflow: hp decrement gated by hp!=0; rounds saturate at ROUNDS_TO_WIN.
// TESTING (overrides HP_MAX=3, ROUNDS_TO_WIN=2, INVULN_CYCLES=4, ROUND_PAUSE_CYCLES=8)
//  1 rst high, release; hold select 20 cycles -> single IDLE->PLAY, one o_round_reset pulse,
//    HP=3/3.
//  2 PLAY; player_hit held 10 cycles, shield=0 -> player_hp 3->2->1
//    (2nd hit 5 cycles after 1st), invuln flag high 4 cycles after each.
//  3 enemy_hit with enemy_shield=1 for 10 cycles -> enemy_hp stays 3, enemy_invuln stays 0.
//  4 enemy_hp to 0 twice (ROUND_END 8 cycles between) -> player_rounds 1 then 2, state WIN;
//    select rise -> IDLE, rounds 0.
//  5 both sides at hp=1, player_hit & enemy_hit same cycle -> hp 0/0, no score,
//    ROUND_END, reload 3/3.
//  6 assert rst in ROUND_END mid-pause -> IDLE, HP 3/3, rounds 0, o_ai_tick=0 immediately.

Source files
------------

// File: rtl/match_controller.sv
// match_controller: best-of-N duel match sequencer. Tracks per-side HP, round
// scores and post-hit invulnerability, paces the pause between rounds, and
// produces the round_reset respawn pulse and the enemy AI tick strobe.
module match_controller #(
    parameter int HP_MAX             = 3,
    parameter int ROUNDS_TO_WIN      = 2,
    parameter int INVULN_CYCLES      = 32,
    parameter int ROUND_PAUSE_CYCLES = 64,
    parameter int AI_PERIOD_LOG2     = 7,
    localparam int HW = $clog2(HP_MAX + 1),
    localparam int RW = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          select,
    input  logic          player_hit,
    input  logic          player_shield,
    input  logic          enemy_hit,
    input  logic          enemy_shield,
    output logic [2:0]    o_state,
    output logic          o_is_gaming,
    output logic [HW-1:0] o_player_hp,
    output logic [HW-1:0] o_enemy_hp,
    output logic [RW-1:0] o_player_rounds,
    output logic [RW-1:0] o_enemy_rounds,
    output logic          o_player_invuln,
    output logic          o_enemy_invuln,
    output logic          o_round_reset,
    output logic          o_ai_tick
);

    // Invulnerability counter needs at least one bit even when the window is disabled.
    localparam int IW = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
    localparam int PW = $clog2(ROUND_PAUSE_CYCLES + 1);

    localparam logic [HW-1:0] HP_INIT    = HW'(HP_MAX);
    localparam logic [RW-1:0] RND_WIN    = RW'(ROUNDS_TO_WIN);
    localparam logic [IW-1:0] INV_INIT   = IW'(INVULN_CYCLES);
    localparam logic [PW-1:0] PAUSE_INIT = PW'(ROUND_PAUSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_ROUND_END = 3'd2,
        S_WIN       = 3'd3,
        S_LOSE      = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic                      sel_q;
    logic [HW-1:0]             php_q, php_d;
    logic [HW-1:0]             ehp_q, ehp_d;
    logic [RW-1:0]             prnd_q, prnd_d;
    logic [RW-1:0]             ernd_q, ernd_d;
    logic [IW-1:0]             pinv_q, pinv_d;
    logic [IW-1:0]             einv_q, einv_d;
    logic [PW-1:0]             pause_q, pause_d;
    logic [AI_PERIOD_LOG2-1:0] ai_cnt_q, ai_cnt_d;
    logic                      rr_q, rr_d;
    logic                      tick_q, tick_d;

    logic                      sel_rise;
    logic                      p_acc;
    logic                      e_acc;
    logic [RW-1:0]             prnd_inc;
    logic [RW-1:0]             ernd_inc;

    // A held button produces exactly one event on its first high cycle.
    assign sel_rise = select & ~sel_q;

    // A hit only counts when unshielded, outside the invulnerability window
    // and while the side still has HP left to lose.
    assign p_acc = player_hit & ~player_shield & (pinv_q == '0) & (php_q != '0);
    assign e_acc = enemy_hit  & ~enemy_shield  & (einv_q == '0) & (ehp_q != '0);

    // Round scores saturate so they can never run past the winning count.
    assign prnd_inc = (prnd_q == RND_WIN) ? prnd_q : prnd_q + 1'b1;
    assign ernd_inc = (ernd_q == RND_WIN) ? ernd_q : ernd_q + 1'b1;

    // Next-state and datapath update for the match sequencer.
    always_comb begin
        state_d  = state_q;
        php_d    = php_q;
        ehp_d    = ehp_q;
        prnd_d   = prnd_q;
        ernd_d   = ernd_q;
        pinv_d   = '0;
        einv_d   = '0;
        pause_d  = pause_q;
        ai_cnt_d = '0;
        rr_d     = 1'b0;
        tick_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel_rise) begin
                    state_d = S_PLAY;
                    php_d   = HP_INIT;
                    ehp_d   = HP_INIT;
                    prnd_d  = '0;
                    ernd_d  = '0;
                    rr_d    = 1'b1;
                end
            end

            S_PLAY: begin
                if (p_acc) begin
                    php_d  = php_q - 1'b1;
                    pinv_d = INV_INIT;
                end else if (pinv_q != '0) begin
                    pinv_d = pinv_q - 1'b1;
                end

                if (e_acc) begin
                    ehp_d  = ehp_q - 1'b1;
                    einv_d = INV_INIT;
                end else if (einv_q != '0) begin
                    einv_d = einv_q - 1'b1;
                end

                // Round outcome is judged on the HP already registered.
                if ((php_q == '0) && (ehp_q == '0)) begin
                    state_d = S_ROUND_END;
                    pause_d = PAUSE_INIT;
                end else if (ehp_q == '0) begin
                    prnd_d  = prnd_inc;
                    state_d = (prnd_inc == RND_WIN) ? S_WIN : S_ROUND_END;
                    pause_d = PAUSE_INIT;
                end else if (php_q == '0) begin
                    ernd_d  = ernd_inc;
                    state_d = (ernd_inc == RND_WIN) ? S_LOSE : S_ROUND_END;
                    pause_d = PAUSE_INIT;
                end

                // The tick is suppressed if play is about to stop.
                if (state_d == S_PLAY) begin
                    ai_cnt_d = ai_cnt_q + 1'b1;
                    tick_d   = (ai_cnt_q == '1);
                end
            end

            S_ROUND_END: begin
                if (pause_q == '0) begin
                    state_d = S_PLAY;
                    php_d   = HP_INIT;
                    ehp_d   = HP_INIT;
                    rr_d    = 1'b1;
                end else begin
                    pause_d = pause_q - 1'b1;
                end
            end

            S_WIN, S_LOSE: begin
                if (sel_rise) begin
                    state_d = S_IDLE;
                    php_d   = HP_INIT;
                    ehp_d   = HP_INIT;
                    prnd_d  = '0;
                    ernd_d  = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any match in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            php_q    <= HP_INIT;
            ehp_q    <= HP_INIT;
            prnd_q   <= '0;
            ernd_q   <= '0;
            pinv_q   <= '0;
            einv_q   <= '0;
            pause_q  <= '0;
            ai_cnt_q <= '0;
            rr_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= select;
            php_q    <= php_d;
            ehp_q    <= ehp_d;
            prnd_q   <= prnd_d;
            ernd_q   <= ernd_d;
            pinv_q   <= pinv_d;
            einv_q   <= einv_d;
            pause_q  <= pause_d;
            ai_cnt_q <= ai_cnt_d;
            rr_q     <= rr_d;
            tick_q   <= tick_d;
        end
    end

    assign o_state         = state_q;
    assign o_is_gaming     = (state_q == S_PLAY);
    assign o_player_hp     = php_q;
    assign o_enemy_hp      = ehp_q;
    assign o_player_rounds = prnd_q;
    assign o_enemy_rounds  = ernd_q;
    assign o_player_invuln = (pinv_q != '0);
    assign o_enemy_invuln  = (einv_q != '0);
    assign o_round_reset   = rr_q;
    assign o_ai_tick       = tick_q;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed match scenarios followed by randomized play,
// every cycle compared against a behavioural model of the match rules.
module tb_match_controller;

    localparam int HP    = 3;
    localparam int RWIN  = 2;
    localparam int INV   = 4;
    localparam int PAUSE = 8;
    localparam int AIL   = 3;
    localparam int AIP   = 1 << AIL;

    logic       clk = 1'b0;
    logic       rst;
    logic       select;
    logic       player_hit;
    logic       player_shield;
    logic       enemy_hit;
    logic       enemy_shield;
    logic [2:0] o_state;
    logic       o_is_gaming;
    logic [1:0] o_player_hp;
    logic [1:0] o_enemy_hp;
    logic [1:0] o_player_rounds;
    logic [1:0] o_enemy_rounds;
    logic       o_player_invuln;
    logic       o_enemy_invuln;
    logic       o_round_reset;
    logic       o_ai_tick;

    int total = 0;
    int bad   = 0;

    // Model state: plain integers, state 0..4 as reported on o_state.
    int m_state, m_php, m_ehp, m_prnd, m_ernd, m_pinv, m_einv;
    int m_endcyc, m_play, m_rr, m_tick, m_selq;

    match_controller #(
        .HP_MAX(HP), .ROUNDS_TO_WIN(RWIN), .INVULN_CYCLES(INV),
        .ROUND_PAUSE_CYCLES(PAUSE), .AI_PERIOD_LOG2(AIL)
    ) dut (
        .clk(clk), .rst(rst), .select(select),
        .player_hit(player_hit), .player_shield(player_shield),
        .enemy_hit(enemy_hit), .enemy_shield(enemy_shield),
        .o_state(o_state), .o_is_gaming(o_is_gaming),
        .o_player_hp(o_player_hp), .o_enemy_hp(o_enemy_hp),
        .o_player_rounds(o_player_rounds), .o_enemy_rounds(o_enemy_rounds),
        .o_player_invuln(o_player_invuln), .o_enemy_invuln(o_enemy_invuln),
        .o_round_reset(o_round_reset), .o_ai_tick(o_ai_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_php = HP; m_ehp = HP; m_prnd = 0; m_ernd = 0;
        m_pinv = 0; m_einv = 0; m_endcyc = 0; m_play = 0;
        m_rr = 0; m_tick = 0; m_selq = 0;
    endtask

    // One clock of the match rules, from the inputs seen at this edge.
    task automatic model_step();
        int  n_state, n_php, n_ehp, n_prnd, n_ernd, n_pinv, n_einv;
        int  n_endcyc, n_play, n_rr, n_tick;
        bit  rise, pa, ea;
        if (rst) begin
            model_reset();
            return;
        end
        rise    = select && (m_selq == 0);
        n_state = m_state; n_php = m_php; n_ehp = m_ehp;
        n_prnd  = m_prnd;  n_ernd = m_ernd;
        n_pinv  = 0; n_einv = 0; n_endcyc = m_endcyc;
        n_play  = 0; n_rr = 0; n_tick = 0;
        case (m_state)
            0: if (rise) begin
                n_state = 1; n_php = HP; n_ehp = HP; n_prnd = 0; n_ernd = 0; n_rr = 1;
            end
            1: begin
                pa = player_hit && !player_shield && (m_pinv == 0) && (m_php > 0);
                ea = enemy_hit  && !enemy_shield  && (m_einv == 0) && (m_ehp > 0);
                if (pa) begin n_php = m_php - 1; n_pinv = INV; end
                else n_pinv = (m_pinv > 0) ? m_pinv - 1 : 0;
                if (ea) begin n_ehp = m_ehp - 1; n_einv = INV; end
                else n_einv = (m_einv > 0) ? m_einv - 1 : 0;
                if (m_php == 0 && m_ehp == 0) begin
                    n_state = 2; n_endcyc = 0;
                end else if (m_ehp == 0) begin
                    n_prnd = (m_prnd < RWIN) ? m_prnd + 1 : m_prnd;
                    n_state = (n_prnd == RWIN) ? 3 : 2; n_endcyc = 0;
                end else if (m_php == 0) begin
                    n_ernd = (m_ernd < RWIN) ? m_ernd + 1 : m_ernd;
                    n_state = (n_ernd == RWIN) ? 4 : 2; n_endcyc = 0;
                end
                if (n_state == 1) begin
                    n_play = m_play + 1;
                    n_tick = ((m_play % AIP) == AIP - 1) ? 1 : 0;
                end
            end
            2: begin
                if (m_endcyc == PAUSE - 1) begin
                    n_state = 1; n_php = HP; n_ehp = HP; n_rr = 1;
                end else begin
                    n_endcyc = m_endcyc + 1;
                end
            end
            default: if (rise) begin
                n_state = 0; n_php = HP; n_ehp = HP; n_prnd = 0; n_ernd = 0;
            end
        endcase
        m_state = n_state; m_php = n_php; m_ehp = n_ehp; m_prnd = n_prnd;
        m_ernd = n_ernd; m_pinv = n_pinv; m_einv = n_einv; m_endcyc = n_endcyc;
        m_play = n_play; m_rr = n_rr; m_tick = n_tick; m_selq = select;
    endtask

    task automatic compare_all();
        check("state",    o_state,          m_state);
        check("gaming",   o_is_gaming,      (m_state == 1) ? 1 : 0);
        check("p_hp",     o_player_hp,      m_php);
        check("e_hp",     o_enemy_hp,       m_ehp);
        check("p_rounds", o_player_rounds,  m_prnd);
        check("e_rounds", o_enemy_rounds,   m_ernd);
        check("p_invuln", o_player_invuln,  (m_pinv != 0) ? 1 : 0);
        check("e_invuln", o_enemy_invuln,   (m_einv != 0) ? 1 : 0);
        check("round_rst", o_round_reset,   m_rr);
        check("ai_tick",  o_ai_tick,        m_tick);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Step while the DUT stays in state st; an expired budget fails the check.
    task automatic wait_leave(input int st, input int maxc, input string tag, output int n);
        n = 0;
        while (o_state == st && n < maxc) begin
            step();
            n++;
        end
        check(tag, (o_state != st) ? 1 : 0, 1);
    endtask

    // Reset asserted mid-cycle, away from any clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_cnt, inv_cnt, prev_hp, idx1, idx2, n, dens_p, dens_e;
        rst = 1'b1; select = 1'b0;
        player_hit = 1'b0; player_shield = 1'b0;
        enemy_hit = 1'b0; enemy_shield = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_state", o_state, 0);
        check("rst_php", o_player_hp, HP);
        check("rst_ehp", o_enemy_hp, HP);
        rst = 1'b0;
        step();

        // Held select starts exactly one match.
        select = 1'b1; rr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            rr_cnt += o_round_reset;
        end
        select = 1'b0;
        check("t1_rr_pulses", rr_cnt, 1);
        check("t1_state", o_state, 1);
        check("t1_hp", o_player_hp * 10 + o_enemy_hp, 33);

        // Held player hit: second hit lands 5 cycles after the first.
        player_hit = 1'b1; inv_cnt = 0; prev_hp = o_player_hp; idx1 = -1; idx2 = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            inv_cnt += o_player_invuln;
            if (o_player_hp != prev_hp) begin
                if (idx1 < 0) idx1 = i; else idx2 = i;
                prev_hp = o_player_hp;
            end
        end
        player_hit = 1'b0;
        check("t2_php", o_player_hp, 1);
        check("t2_hit_gap", idx2 - idx1, 5);
        check("t2_invuln_cycles", inv_cnt, 8);

        // Shielded enemy takes nothing.
        enemy_hit = 1'b1; enemy_shield = 1'b1; inv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            inv_cnt += o_enemy_invuln;
        end
        enemy_hit = 1'b0; enemy_shield = 1'b0;
        check("t3_ehp", o_enemy_hp, 3);
        check("t3_einv_cycles", inv_cnt, 0);

        // Player wins two rounds.
        enemy_hit = 1'b1;
        wait_leave(1, 40, "t4_r1_end", n);
        enemy_hit = 1'b0;
        check("t4_r1_state", o_state, 2);
        check("t4_r1_prnd", o_player_rounds, 1);
        wait_leave(2, 40, "t4_pause_end", n);
        check("t4_pause_len", n, PAUSE);
        check("t4_reload", o_player_hp * 10 + o_enemy_hp, 33);
        enemy_hit = 1'b1;
        wait_leave(1, 40, "t4_r2_end", n);
        enemy_hit = 1'b0;
        check("t4_win_state", o_state, 3);
        check("t4_win_prnd", o_player_rounds, 2);
        repeat (3) step();
        select = 1'b1; step(); select = 1'b0; step();
        check("t4_idle_state", o_state, 0);
        check("t4_idle_prnd", o_player_rounds, 0);

        // Simultaneous lethal hits give a draw.
        select = 1'b1; step(); select = 1'b0;
        player_hit = 1'b1; enemy_hit = 1'b1;
        repeat (6) step();
        player_hit = 1'b0; enemy_hit = 1'b0;
        repeat (6) step();
        check("t5_hp11", o_player_hp * 10 + o_enemy_hp, 11);
        player_hit = 1'b1; enemy_hit = 1'b1;
        step();
        player_hit = 1'b0; enemy_hit = 1'b0;
        check("t5_hp00", o_player_hp * 10 + o_enemy_hp, 0);
        step();
        check("t5_state", o_state, 2);
        check("t5_rounds", o_player_rounds * 10 + o_enemy_rounds, 0);
        wait_leave(2, 40, "t5_pause_end", n);
        check("t5_reload", o_player_hp * 10 + o_enemy_hp, 33);

        // Reset in the middle of the inter-round pause.
        enemy_hit = 1'b1;
        wait_leave(1, 40, "t6_r_end", n);
        enemy_hit = 1'b0;
        repeat (3) step();
        check("t6_pre_state", o_state, 2);
        async_reset();
        check("t6_state", o_state, 0);
        check("t6_hp", o_player_hp * 10 + o_enemy_hp, 33);
        check("t6_rounds", o_player_rounds * 10 + o_enemy_rounds, 0);
        check("t6_tick", o_ai_tick, 0);
        step();
        rst = 1'b0;
        step();

        // Randomized play with varying hit density and occasional resets.
        dens_p = 20; dens_e = 20;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 150) == 0) begin
                dens_p = $urandom_range(0, 60);
                dens_e = $urandom_range(0, 60);
            end
            if ($urandom_range(0, 9) == 0) select = ~select;
            player_hit    = ($urandom_range(0, 99) < dens_p);
            enemy_hit     = ($urandom_range(0, 99) < dens_e);
            player_shield = ($urandom_range(0, 3) == 0);
            enemy_shield  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
                step();
                rst = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
